nn_bgt_array: RTL and testbench

Multi-channel, runtime-configurable spike burst gate for the stochastic neural-network datapath. Each of `N_CH` independent channels watches its spike input over a sliding `MEMSIZE`-sample window. When the window's spike count reaches a programmable threshold, the channel emits a burst of `PULSE_LEN` ones, then holds off for `REFR_LEN` cycles. It sits between neuron activation streams and downstream burst-consuming layers, and generalises the fixed all-ones, fixed-duration gate to a count threshold, live-programmable durations, an optional window clear and per-channel status.

---
 rtl/nn_bgt_array_if.sv | 45 ++++
 rtl/nn_bgt_array.sv | 141 ++++++++++++++
 tb/tb_nn_bgt_array.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/nn_bgt_array_if.sv
// ---------------------------------------------------------------------------
// nn_bgt_array_if
// Bundles the spike inputs, the shared runtime configuration and the
// per-channel status outputs of the burst gate array.
//
// Signals
//   IN          [N_CH]   per-channel spike input
//   THRESHOLD   [TW]     window spike count needed to fire (shared)
//   PULSE_LEN   [CNT_W]  burst length in cycles (0 behaves as 1)
//   REFR_LEN    [CNT_W]  refractory length in cycles (0 = none)
//   CLR_ON_FIRE          zero the channel window on the fire edge
//   OUT         [N_CH]   burst output
//   FIRE        [N_CH]   one-cycle strobe on the first burst cycle
//   REFR        [N_CH]   high while the channel is refractory
//
// Modports
//   master : stimulus side, drives inputs and observes status
//   slave  : gate array side
// ---------------------------------------------------------------------------
interface nn_bgt_array_if #(
  parameter int N_CH  = 4,
  parameter int TW    = 4,
  parameter int CNT_W = 8
);

  logic [N_CH-1:0]  IN;
  logic [TW-1:0]    THRESHOLD;
  logic [CNT_W-1:0] PULSE_LEN;
  logic [CNT_W-1:0] REFR_LEN;
  logic             CLR_ON_FIRE;
  logic [N_CH-1:0]  OUT;
  logic [N_CH-1:0]  FIRE;
  logic [N_CH-1:0]  REFR;

  modport master (
    output IN, THRESHOLD, PULSE_LEN, REFR_LEN, CLR_ON_FIRE,
    input  OUT, FIRE, REFR
  );

  modport slave (
    input  IN, THRESHOLD, PULSE_LEN, REFR_LEN, CLR_ON_FIRE,
    output OUT, FIRE, REFR
  );

endinterface

// File: rtl/nn_bgt_array.sv
// ---------------------------------------------------------------------------
// nn_bgt_array
// Multi-channel spike burst gate. Each channel keeps a sliding window of its
// last MEMSIZE spike samples; once the window popcount reaches THRESHOLD the
// channel emits a burst of max(PULSE_LEN,1) ones followed by REFR_LEN
// refractory cycles, during which new hits are ignored.
//
// Ports
//   CLK   clock, rising edge
//   INIT  asynchronous active-high reset
//   bus   nn_bgt_array_if.slave (spike inputs, live configuration, status)
// ---------------------------------------------------------------------------
module nn_bgt_array #(
  parameter int N_CH    = 4,
  parameter int MEMSIZE = 8,
  parameter int TW      = 4,
  parameter int CNT_W   = 8
) (
  input logic           CLK,
  input logic           INIT,
  nn_bgt_array_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    REFRACT = 2'd2
  } state_t;

  state_t             state_q [N_CH];
  state_t             state_d [N_CH];
  logic [CNT_W-1:0]   k_q     [N_CH];
  logic [CNT_W-1:0]   k_d     [N_CH];
  logic [CNT_W:0]     k_inc   [N_CH];
  logic [MEMSIZE-1:0] mem_q   [N_CH];
  logic [MEMSIZE-1:0] mem_d   [N_CH];
  logic [TW-1:0]      cnt     [N_CH];
  logic [N_CH-1:0]    hit;
  logic [N_CH-1:0]    fire_q;
  logic [N_CH-1:0]    fire_d;

  logic [CNT_W-1:0]   pulse_eff;
  logic [CNT_W:0]     pulse_ext;
  logic [CNT_W:0]     refr_ext;

  // Lengths are compared one bit wider than K so K+1 can never wrap.
  always_comb begin
    pulse_eff = (bus.PULSE_LEN == '0) ? CNT_W'(1) : bus.PULSE_LEN;
    pulse_ext = {1'b0, pulse_eff};
    refr_ext  = {1'b0, bus.REFR_LEN};
  end

  // Window popcount and threshold test; a zero threshold never fires.
  always_comb begin
    hit = '0;
    for (int c = 0; c < N_CH; c++) begin
      cnt[c] = '0;
      for (int i = 0; i < MEMSIZE; i++) begin
        cnt[c] = cnt[c] + TW'(mem_q[c][i]);
      end
      hit[c] = (bus.THRESHOLD != '0) && (cnt[c] >= bus.THRESHOLD);
    end
  end

  // Next-state logic per channel. The window shifts in every state; only the
  // fire edge with CLR_ON_FIRE set replaces the shift with an all-zero window.
  // The >= compares make a length lowered below K end the phase on the next
  // edge instead of running on to a wrap.
  always_comb begin
    fire_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      state_d[c] = state_q[c];
      k_d[c]     = k_q[c];
      k_inc[c]   = {1'b0, k_q[c]} + {{CNT_W{1'b0}}, 1'b1};
      mem_d[c]   = {mem_q[c][MEMSIZE-2:0], bus.IN[c]};
      case (state_q[c])
        IDLE: begin
          if (hit[c]) begin
            state_d[c] = BURST;
            k_d[c]     = '0;
            fire_d[c]  = 1'b1;
            if (bus.CLR_ON_FIRE) begin
              mem_d[c] = '0;
            end
          end
        end
        BURST: begin
          if (k_inc[c] >= pulse_ext) begin
            k_d[c]     = '0;
            state_d[c] = (bus.REFR_LEN != '0) ? REFRACT : IDLE;
          end else begin
            k_d[c] = k_inc[c][CNT_W-1:0];
          end
        end
        REFRACT: begin
          if (k_inc[c] >= refr_ext) begin
            k_d[c]     = '0;
            state_d[c] = IDLE;
          end else begin
            k_d[c] = k_inc[c][CNT_W-1:0];
          end
        end
        default: begin
          state_d[c] = IDLE;
          k_d[c]     = '0;
        end
      endcase
    end
  end

  // State, counter, window and strobe registers for all channels.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= IDLE;
        k_q[c]     <= '0;
        mem_q[c]   <= '0;
      end
      fire_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= state_d[c];
        k_q[c]     <= k_d[c];
        mem_q[c]   <= mem_d[c];
      end
      fire_q <= fire_d;
    end
  end

  // Status outputs decode straight from flops so they cannot glitch.
  always_comb begin
    bus.OUT  = '0;
    bus.REFR = '0;
    bus.FIRE = fire_q;
    for (int c = 0; c < N_CH; c++) begin
      bus.OUT[c]  = (state_q[c] == BURST);
      bus.REFR[c] = (state_q[c] == REFRACT);
    end
  end

endmodule

// File: tb/tb_nn_bgt_array.sv
// ---------------------------------------------------------------------------
// tb_nn_bgt_array
// Directed bench for nn_bgt_array: reset behaviour, basic burst timing,
// refractory suppression, window clear, boundary configurations and channel
// independence. Status is packed as {OUT,REFR,FIRE} and compared each cycle.
// ---------------------------------------------------------------------------
module tb_nn_bgt_array;

  logic CLK;
  logic INIT;
  int   comp_count;
  int   fail_count;

  nn_bgt_array_if #(.N_CH(4), .TW(4), .CNT_W(8)) bus ();

  nn_bgt_array #(
    .N_CH(4), .MEMSIZE(8), .TW(4), .CNT_W(8)
  ) dut (
    .CLK (CLK),
    .INIT(INIT),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    comp_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] in_v, input logic [3:0] thr,
                               input logic [7:0] plen, input logic [7:0] rlen,
                               input logic clr);
    bus.IN          = in_v;
    bus.THRESHOLD   = thr;
    bus.PULSE_LEN   = plen;
    bus.REFR_LEN    = rlen;
    bus.CLR_ON_FIRE = clr;
  endtask

  // Pulse reset and release on a falling edge; the next rising edge is edge 0.
  task automatic doReset();
    INIT = 1'b1;
    #1;
    @(negedge CLK);
    INIT = 1'b0;
  endtask

  function automatic logic [11:0] status();
    return {bus.OUT, bus.REFR, bus.FIRE};
  endfunction

  // Expected {OUT,REFR,FIRE} for channels under continuous hit that first
  // fire after edge f0 and refire every per edges.
  function automatic logic [11:0] expVec(int e, int f0, int pl, int rl,
                                         int per, logic [3:0] mask);
    logic o, r, f;
    int   ph;
    o = 1'b0; r = 1'b0; f = 1'b0;
    if (e >= f0) begin
      ph = (e - f0) % per;
      o  = (ph < pl);
      r  = (ph >= pl) && (ph < pl + rl);
      f  = (ph == 0);
    end
    return {mask & {4{o}}, mask & {4{r}}, mask & {4{f}}};
  endfunction

  task automatic runModel(input string tag, input int n, input int f0,
                          input int pl, input int rl, input int per,
                          input logic [3:0] mask);
    for (int e = 0; e < n; e++) begin
      @(posedge CLK);
      #1;
      checkOutput($sformatf("%s e%0d", tag, e), 32'(status()),
                  32'(expVec(e, f0, pl, rl, per, mask)));
    end
  endtask

  initial begin
    comp_count = 0;
    fail_count = 0;
    INIT = 1'b0;
    applyStimulus(4'b0000, 4'd3, 8'd4, 8'd5, 1'b0);

    // Reset state
    #1 INIT = 1'b1;
    #2;
    checkOutput("rst OUT", 32'(bus.OUT), 32'h0);
    checkOutput("rst FIRE", 32'(bus.FIRE), 32'h0);
    checkOutput("rst REFR", 32'(bus.REFR), 32'h0);
    @(negedge CLK);
    INIT = 1'b0;

    // Basic burst: three spikes on channel 0 at edges 0..2
    for (int e = 0; e < 16; e++) begin
      bus.IN = (e <= 2) ? 4'b0001 : 4'b0000;
      @(posedge CLK);
      #1;
      checkOutput($sformatf("basic e%0d", e), 32'(status()),
                  32'({3'b000, 1'(e >= 3 && e <= 6), 3'b000,
                       1'(e >= 7 && e <= 11), 3'b000, 1'(e == 3)}));
    end

    // Reset mid-burst, then the window must refill before refiring
    bus.IN = 4'b0001;
    for (int e = 0; e < 5; e++) begin
      @(posedge CLK);
    end
    #1;
    checkOutput("pre-reset OUT", 32'(bus.OUT), 32'h1);
    #2 INIT = 1'b1;
    #1;
    checkOutput("mid rst OUT", 32'(bus.OUT), 32'h0);
    checkOutput("mid rst FIRE", 32'(bus.FIRE), 32'h0);
    checkOutput("mid rst REFR", 32'(bus.REFR), 32'h0);
    @(negedge CLK);
    INIT = 1'b0;
    runModel("post-rst", 5, 3, 4, 5, 10, 4'b0001);

    // Refractory suppression on channel 1
    applyStimulus(4'b0010, 4'd3, 8'd4, 8'd5, 1'b0);
    doReset();
    runModel("refr", 36, 3, 4, 5, 10, 4'b0010);

    // Window clear off / on on channel 2
    applyStimulus(4'b0100, 4'd8, 8'd2, 8'd2, 1'b0);
    doReset();
    runModel("noclr", 25, 8, 2, 2, 5, 4'b0100);
    applyStimulus(4'b0100, 4'd8, 8'd2, 8'd2, 1'b1);
    doReset();
    runModel("clr", 30, 8, 2, 2, 9, 4'b0100);

    // Thresholds that can never hit
    applyStimulus(4'b1111, 4'd0, 8'd2, 8'd2, 1'b0);
    doReset();
    runModel("thr0", 12, 0, 1, 0, 1, 4'b0000);
    applyStimulus(4'b1111, 4'd9, 8'd2, 8'd2, 1'b0);
    doReset();
    runModel("thr9", 12, 0, 1, 0, 1, 4'b0000);

    // PULSE_LEN of zero gives a single-cycle burst
    applyStimulus(4'b1111, 4'd1, 8'd0, 8'd3, 1'b0);
    doReset();
    runModel("plen0", 12, 1, 1, 3, 5, 4'b1111);

    // REFR_LEN of zero: one idle cycle between bursts
    applyStimulus(4'b1111, 4'd1, 8'd2, 8'd0, 1'b0);
    doReset();
    runModel("rlen0", 10, 1, 2, 0, 3, 4'b1111);

    // Shorten PULSE_LEN from 10 to 2 while K is 5
    applyStimulus(4'b1111, 4'd1, 8'd10, 8'd0, 1'b0);
    doReset();
    for (int e = 0; e < 7; e++) begin
      @(posedge CLK);
      #1;
      checkOutput($sformatf("shrink e%0d", e), 32'(bus.OUT),
                  (e >= 1) ? 32'hF : 32'h0);
    end
    bus.PULSE_LEN = 8'd2;
    @(posedge CLK);
    #1;
    checkOutput("shrink end", 32'(status()), 32'h000);
    @(posedge CLK);
    #1;
    checkOutput("shrink refire", 32'(status()), 32'hF0F);

    // Independence: channels 0 and 3 fire together, 1 and 2 stay quiet
    applyStimulus(4'b1001, 4'd3, 8'd4, 8'd5, 1'b0);
    doReset();
    runModel("indep", 15, 3, 4, 5, 10, 4'b1001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             comp_count, fail_count);
    $finish;
  end

endmodule
